// File: rtl/bilinear_blend.sv
`default_nettype none
// ============================================================================
// Module      : bilinear_blend
// Description : Three-stage bilinear interpolator. Blends a 2x2 source
//               neighbourhood with fractional weights into one 8-bit pixel
//               and emits it as an AXI-stream video master with regenerated
//               end-of-line (tlast) and start-of-frame (tuser) markers.
// Revision    : 1.0 - initial release
// ============================================================================
module bilinear_blend #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              rst,        // active-low, asynchronous assert
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic [7:0]        lu,
  input  logic [7:0]        ru,
  input  logic [7:0]        ld,
  input  logic [7:0]        rd,
  input  logic [FRAC_W-1:0] fx,
  input  logic [FRAC_W-1:0] fy,
  output logic [7:0]        m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              m_tuser,
  output logic              err_last
);

  // Partial-sum widths: one interpolation axis adds FRAC_W bits of weight.
  localparam int TW = 8 + FRAC_W;
  localparam int VW = 8 + 2 * FRAC_W;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  // Weight 1.0 needs one bit more than the fractional weight itself.
  localparam logic [FRAC_W:0] C_ONE  = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [VW-1:0]   C_HALF = VW'(1) << (2 * FRAC_W - 1);
  localparam logic [CW-1:0]   C_COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]   C_ROW_LAST = RW'(IMG_HEIGHT - 1);

  // Position counters
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          err_q, err_d;

  // Stage 1: horizontal blends plus the vertical weight carried along
  logic              v1_q, v1_d;
  logic [TW-1:0]     top_q, top_d;
  logic [TW-1:0]     bot_q, bot_d;
  logic [FRAC_W-1:0] fy1_q, fy1_d;
  logic              last1_q, last1_d;
  logic              user1_q, user1_d;

  // Stage 2: vertical blend
  logic          v2_q, v2_d;
  logic [VW-1:0] sum_q, sum_d;
  logic          last2_q, last2_d;
  logic          user2_q, user2_d;

  // Stage 3: rounded output pixel
  logic       v3_q, v3_d;
  logic [7:0] pix_q, pix_d;
  logic       last3_q, last3_d;
  logic       user3_q, user3_d;

  logic              adv;
  logic              acc;
  logic              col_end;
  logic              row_end;
  logic [FRAC_W:0]   wx_n;
  logic [FRAC_W:0]   wy_n;

  // The whole pipe moves as one; it only freezes when the output is stuck.
  assign adv     = !v3_q || m_tready;
  assign acc     = s_valid && adv;
  assign col_end = (col_q == C_COL_LAST);
  assign row_end = (row_q == C_ROW_LAST);
  assign wx_n    = C_ONE - {1'b0, fx};
  assign wy_n    = C_ONE - {1'b0, fy1_q};

  assign s_ready  = adv;
  assign m_tvalid = v3_q;
  assign m_tdata  = pix_q;
  assign m_tlast  = last3_q;
  assign m_tuser  = user3_q;
  assign err_last = err_q;

  // Next-state for the pipeline stages, counters and sticky error flag.
  // Partial sums are bounded by 255 * 2^k, so modular arithmetic at the
  // declared widths is exact.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    v1_d    = v1_q;
    top_d   = top_q;
    bot_d   = bot_q;
    fy1_d   = fy1_q;
    last1_d = last1_q;
    user1_d = user1_q;
    v2_d    = v2_q;
    sum_d   = sum_q;
    last2_d = last2_q;
    user2_d = user2_q;
    v3_d    = v3_q;
    pix_d   = pix_q;
    last3_d = last3_q;
    user3_d = user3_q;

    if (adv) begin
      v1_d    = s_valid;
      top_d   = TW'(lu) * TW'(wx_n) + TW'(ru) * TW'(fx);
      bot_d   = TW'(ld) * TW'(wx_n) + TW'(rd) * TW'(fx);
      fy1_d   = fy;
      last1_d = col_end;
      user1_d = (col_q == '0) && (row_q == '0);

      v2_d    = v1_q;
      sum_d   = VW'(top_q) * VW'(wy_n) + VW'(bot_q) * VW'(fy1_q);
      last2_d = last1_q;
      user2_d = user1_q;

      v3_d    = v2_q;
      pix_d   = 8'((sum_q + C_HALF) >> (2 * FRAC_W));
      last3_d = last2_q;
      user3_d = user2_q;
    end

    if (acc) begin
      if (s_last != col_end) begin
        err_d = 1'b1;
      end
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // State registers; reset drops every in-flight pixel and restarts at (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      v1_q    <= 1'b0;
      top_q   <= '0;
      bot_q   <= '0;
      fy1_q   <= '0;
      last1_q <= 1'b0;
      user1_q <= 1'b0;
      v2_q    <= 1'b0;
      sum_q   <= '0;
      last2_q <= 1'b0;
      user2_q <= 1'b0;
      v3_q    <= 1'b0;
      pix_q   <= '0;
      last3_q <= 1'b0;
      user3_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      err_q   <= err_d;
      v1_q    <= v1_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      fy1_q   <= fy1_d;
      last1_q <= last1_d;
      user1_q <= user1_d;
      v2_q    <= v2_d;
      sum_q   <= sum_d;
      last2_q <= last2_d;
      user2_q <= user2_d;
      v3_q    <= v3_d;
      pix_q   <= pix_d;
      last3_q <= last3_d;
      user3_q <= user3_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bilinear_blend.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bilinear_blend
// Description : Directed self-checking bench for bilinear_blend with a
//               queue-based scoreboard of expected output beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bilinear_blend;

  localparam int IW = 16;
  localparam int IH = 4;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [7:0]    lu = '0, ru = '0, ld = '0, rd = '0;
  logic [FW-1:0] fx = '0, fy = '0;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          m_tuser;
  logic          err_last;

  bilinear_blend #(
    .IMG_WIDTH (IW),
    .IMG_HEIGHT(IH),
    .FRAC_W    (FW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .lu      (lu),
    .ru      (ru),
    .ld      (ld),
    .rd      (rd),
    .fx      (fx),
    .fy      (fy),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast (m_tlast),
    .m_tuser (m_tuser),
    .err_last(err_last)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         acc_cyc;
    bit         chk_lat;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         tb_col = 0;
  int         tb_row = 0;
  logic [7:0] pend_data = '0;
  bit         pend_lat = 0;
  int         stall_lo = 0;
  int         stall_hi = 0;
  bit         hold_low = 0;
  bit         prev_stall = 0;
  logic [9:0] stall_snap = '0;

  // Watchdog so a wedged run still terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference blend straight from the interpolation formula
  function automatic logic [7:0] blend(input int a, input int b, input int c,
                                       input int d, input int x, input int y);
    int t, u, v;
    t = a * (16 - x) + b * x;
    u = c * (16 - x) + d * x;
    v = t * (16 - y) + u * y;
    return 8'((v + 128) >> 8);
  endfunction

  // One clock: drive m_tready, sample at negedge, score, push, advance.
  task automatic cycle(output bit accepted);
    exp_t e;
    m_tready = !(hold_low || (cyc >= stall_lo && cyc < stall_hi));
    @(negedge clk);
    accepted = 0;
    if (prev_stall) begin
      check("stall_hold_valid", 32'(m_tvalid), 32'd1);
      check("stall_hold_beat", 32'({m_tlast, m_tuser, m_tdata}), 32'(stall_snap));
    end
    prev_stall = m_tvalid && !m_tready;
    if (prev_stall) begin
      stall_snap = {m_tlast, m_tuser, m_tdata};
      check("stall_s_ready", 32'(s_ready), 32'd0);
    end
    if (m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check("spurious_output", 32'(m_tvalid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pixel", 32'(m_tdata), 32'(e.data));
        check("tlast", 32'(m_tlast), 32'(e.last));
        check("tuser", 32'(m_tuser), 32'(e.user));
        if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'd3);
      end
    end
    if (s_valid && s_ready) begin
      e.data    = pend_data;
      e.last    = (tb_col == IW - 1);
      e.user    = (tb_col == 0) && (tb_row == 0);
      e.acc_cyc = cyc;
      e.chk_lat = pend_lat;
      sb.push_back(e);
      accepted = 1;
      if (tb_col == IW - 1) begin
        tb_col = 0;
        tb_row = (tb_row == IH - 1) ? 0 : tb_row + 1;
      end else begin
        tb_col++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input logic [3:0] x, input logic [3:0] y,
                      input logic [7:0] exp, input bit bad_last, input bit lat,
                      output int tries);
    bit acc;
    s_valid = 1; lu = a; ru = b; ld = c; rd = d; fx = x; fy = y;
    s_last = (tb_col == IW - 1) ^ bad_last;
    pend_data = exp;
    pend_lat = lat;
    tries = 0;
    acc = 0;
    do begin
      cycle(acc);
      tries++;
    end while (!acc && tries < 100);
    if (!acc) check("send_timeout", 32'(s_ready), 32'd1);
    s_valid = 0;
    s_last = 0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      cycle(acc);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Assert reset mid-cycle, verify cleared outputs, release after a few edges.
  task automatic do_reset();
    rst = 0;
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tuser", 32'(m_tuser), 32'd0);
    check("rst_err_last", 32'(err_last), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    sb.delete();
    tb_col = 0;
    tb_row = 0;
    prev_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
  endtask

  // Directed sequence
  initial begin
    int t;
    logic [7:0] a, b, c, d;
    logic [3:0] x, y;

    #1;
    do_reset();

    // Identity: fx=fy=0 returns lu exactly, s_ready held high
    send(8'h5A, 8'h13, 8'hC7, 8'h81, 4'd0, 4'd0, 8'h5A, 0, 1, t);
    check("identity_ready", 32'(t), 32'd1);
    drain();

    // Centre blend and full-scale
    send(8'd0, 8'd16, 8'd32, 8'd48, 4'd8, 4'd8, 8'd24, 0, 0, t);
    send(8'd255, 8'd255, 8'd255, 8'd255, 4'd0, 4'd0, 8'd255, 0, 0, t);
    send(8'd255, 8'd255, 8'd255, 8'd255, 4'd15, 4'd15, 8'd255, 0, 0, t);
    send(8'd255, 8'd255, 8'd255, 8'd255, 4'd7, 4'd12, 8'd255, 0, 0, t);
    // Rounding: exact half rounds up, just below half rounds down
    send(8'd1, 8'd0, 8'd0, 8'd0, 4'd8, 4'd0, 8'd1, 0, 0, t);
    send(8'd1, 8'd0, 8'd0, 8'd0, 4'd9, 4'd0, 8'd0, 0, 0, t);
    // Random neighbourhoods against the reference formula
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(255)); b = 8'($urandom_range(255));
      c = 8'($urandom_range(255)); d = 8'($urandom_range(255));
      x = 4'($urandom_range(15));  y = 4'($urandom_range(15));
      send(a, b, c, d, x, y, blend(int'(a), int'(b), int'(c), int'(d), int'(x), int'(y)), 0, 0, t);
    end
    drain();

    // Backpressure: sink stalls for 5 cycles starting 4 cycles into the burst
    do_reset();
    stall_lo = cyc + 4;
    stall_hi = cyc + 9;
    for (int i = 1; i <= 10; i++) begin
      send(8'(i), 8'hFF, 8'hFF, 8'hFF, 4'd0, 4'd0, 8'(i), 0, 0, t);
    end
    drain();
    stall_lo = 0;
    stall_hi = 0;

    // Markers over 65 continuous beats with correct s_last
    do_reset();
    for (int i = 1; i <= 65; i++) begin
      send(8'(i), 8'd0, 8'd0, 8'd0, 4'd0, 4'd0, 8'(i), 0, 0, t);
      if (i == 1 || i == 65) check("marker_stream_ready", 32'(t), 32'd1);
    end
    drain();
    check("err_last_clean", 32'(err_last), 32'd0);

    // Misplaced s_last on beat 10 sets a sticky error
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      send(8'(i), 8'd0, 8'd0, 8'd0, 4'd0, 4'd0, 8'(i), i == 10, 0, t);
    end
    check("err_last_set", 32'(err_last), 32'd1);
    for (int i = 11; i <= 15; i++) begin
      send(8'(i), 8'd0, 8'd0, 8'd0, 4'd0, 4'd0, 8'(i), 0, 0, t);
    end
    drain();
    check("err_last_sticky", 32'(err_last), 32'd1);

    // Reset mid-stream with three beats in flight
    do_reset();
    hold_low = 1;
    send(8'd7, 8'd0, 8'd0, 8'd0, 4'd0, 4'd0, 8'd7, 1, 0, t);
    send(8'd8, 8'd0, 8'd0, 8'd0, 4'd0, 4'd0, 8'd8, 0, 0, t);
    send(8'd9, 8'd0, 8'd0, 8'd0, 4'd0, 4'd0, 8'd9, 0, 0, t);
    check("inflight_valid", 32'(m_tvalid), 32'd1);
    check("inflight_err", 32'(err_last), 32'd1);
    do_reset();
    hold_low = 0;
    for (int i = 1; i <= 17; i++) begin
      send(8'(100 + i), 8'd0, 8'd0, 8'd0, 4'd0, 4'd0, 8'(100 + i), 0, 0, t);
    end
    drain();
    check("post_reset_err", 32'(err_last), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
